// File: rtl/rr_stream_mux_pkg.sv
// Shared routing definitions for the round-robin stream multiplexer.
package rr_stream_mux_pkg;

   typedef enum logic {
      ModeRr    = 1'b0,
      ModeFixed = 1'b1
   } mode_e;

   function automatic int unsigned num_chan(input int unsigned s);
      return 32'd1 << s;
   endfunction

   // Low bit of channel idx within a flattened bus of t-bit slices.
   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned t);
      return idx * t;
   endfunction

endpackage

// File: rtl/recurse_mux.sv
// Combinational 2**S:1 multiplexer built as a binary tree of 2:1 stages.
module recurse_mux #(
   parameter int unsigned S = 2,
   parameter int unsigned T = 8
) (
   input  logic [(2**S)*T-1:0] data,
   input  logic [S-1:0]        ctrl,
   output logic [T-1:0]        sel_data
);

   if (S == 1) begin : g_leaf
      assign sel_data = ctrl[0] ? data[2*T-1:T] : data[T-1:0];
   end else begin : g_node
      localparam int unsigned HalfW = (2**(S-1)) * T;
      logic [T-1:0] lo_data;
      logic [T-1:0] hi_data;

      recurse_mux #(.S(S-1), .T(T)) u_lo (
         .data     (data[HalfW-1:0]),
         .ctrl     (ctrl[S-2:0]),
         .sel_data (lo_data)
      );

      recurse_mux #(.S(S-1), .T(T)) u_hi (
         .data     (data[2*HalfW-1:HalfW]),
         .ctrl     (ctrl[S-2:0]),
         .sel_data (hi_data)
      );

      assign sel_data = ctrl[S-1] ? hi_data : lo_data;
   end

endmodule

// File: rtl/rr_pick.sv
// Combinational grant selection: round-robin after last_grant, or lowest index first.
module rr_pick
   import rr_stream_mux_pkg::*;
#(
   parameter int unsigned S = 2
) (
   input  logic [(2**S)-1:0] req,
   input  logic [S-1:0]      last_grant,
   input  logic              mode,
   output logic [S-1:0]      grant,
   output logic              any_req
);

   localparam int unsigned N = num_chan(S);

   logic         found;
   logic [S-1:0] idx;

   always_comb begin
      grant   = '0;
      any_req = |req;
      found   = 1'b0;
      idx     = '0;
      if (mode == ModeFixed) begin
         for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) grant = i[S-1:0];
         end
      end else begin
         // S-bit add wraps naturally; k = N lands back on last_grant.
         for (int unsigned k = 1; k <= N; k++) begin
            idx = last_grant + k[S-1:0];
            if (!found && req[idx]) begin
               grant = idx;
               found = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rr_stream_mux.sv
// Registered N:1 stream multiplexer with round-robin or fixed-priority arbitration.
module rr_stream_mux
   import rr_stream_mux_pkg::*;
#(
   parameter int unsigned S = 2,
   parameter int unsigned T = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode,
   input  logic [(2**S)-1:0]    in_valid,
   output logic [(2**S)-1:0]    in_ready,
   input  logic [(2**S)*T-1:0]  in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [T-1:0]         out_data,
   output logic [S-1:0]         out_sel
);

   logic [S-1:0] last_grant;
   logic [S-1:0] grant;
   logic         any_req;
   logic         load;
   logic [T-1:0] mux_data;

   // Refill in the same cycle the register drains.
   assign load = !out_valid || out_ready;

   rr_pick #(.S(S)) u_pick (
      .req        (in_valid),
      .last_grant (last_grant),
      .mode       (mode),
      .grant      (grant),
      .any_req    (any_req)
   );

   recurse_mux #(.S(S), .T(T)) u_mux (
      .data     (in_data),
      .ctrl     (grant),
      .sel_data (mux_data)
   );

   always_comb begin
      in_ready = '0;
      if (rst_n && load && any_req) in_ready[grant] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_sel    <= '0;
         last_grant <= '1;
      end else if (load) begin
         if (any_req) begin
            out_valid  <= 1'b1;
            out_data   <= mux_data;
            out_sel    <= grant;
            last_grant <= grant;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux: directed plan sequences plus randomized traffic.
module tb_rr_stream_mux;

   localparam int S = 2;
   localparam int T = 8;
   localparam int N = 4;

   typedef struct packed {
      logic [T-1:0] data;
      logic [S-1:0] sel;
   } item_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           mode = 1'b0;
   logic [N-1:0]   in_valid = '0;
   logic [N-1:0]   in_ready;
   logic [N*T-1:0] in_data = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [T-1:0]   out_data;
   logic [S-1:0]   out_sel;

   item_t        q[$];
   int           total = 0;
   int           bad = 0;
   int           m_last = N - 1;
   logic [N-1:0] exp_ready = '0;
   bit           mon_en = 1'b0;

   logic [N*T-1:0] d_std = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

   always #5 clk = ~clk;

   rr_stream_mux #(.S(S), .T(T)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arbitration: -1 when nobody requests.
   function automatic int pick(input logic [N-1:0] v, input logic m, input int last);
      if (v == '0) return -1;
      if (m) begin
         for (int i = 0; i < N; i++) if (v[i]) return i;
      end else begin
         for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   // One clock of stimulus; model advances after the edge.
   task automatic step(input logic r, input logic m, input logic [N-1:0] v, input logic rdy,
                       input logic [N*T-1:0] d);
      int           g;
      bit           acc;
      item_t        it;
      logic [N-1:0] one;
      one       = 1;
      rst_n     = r;
      mode      = m;
      in_valid  = v;
      out_ready = rdy;
      in_data   = d;
      g         = pick(v, m, m_last);
      acc       = r && (q.size() == 0 || rdy) && (g >= 0);
      exp_ready = acc ? (one << g) : '0;
      it.data   = acc ? d[g*T +: T] : '0;
      it.sel    = acc ? g[S-1:0] : '0;
      @(posedge clk);
      #1;
      if (!r) begin
         q.delete();
         m_last = N - 1;
      end else if (acc) begin
         q.push_back(it);
         m_last = g;
      end
   endtask

   task automatic expect_out(input string name, input logic [T-1:0] d, input logic [S-1:0] s);
      check({name, "_valid"}, out_valid, 1'b1);
      check({name, "_data"}, out_data, d);
      check({name, "_sel"}, out_sel, s);
   endtask

   initial begin : monitor
      wait (mon_en);
      forever begin
         @(negedge clk);
         check("in_ready", in_ready, exp_ready);
         check("out_valid", out_valid, q.size() != 0);
         if (q.size() != 0) begin
            check("sb_data", out_data, q[0].data);
            check("sb_sel", out_sel, q[0].sel);
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   initial begin : driver
      logic [N*T-1:0] d_sp;
      logic [N*T-1:0] d_rnd;
      logic [S-1:0]   s_exp;

      // Reset with everything requesting.
      step(1'b0, 1'b0, 4'hF, 1'b1, d_std);
      mon_en = 1'b1;
      step(1'b0, 1'b0, 4'hF, 1'b1, d_std);
      check("rst_valid", out_valid, 1'b0);
      check("rst_data", out_data, 8'h00);
      check("rst_sel", out_sel, 2'd0);

      // Round-robin rotation and wrap.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 4'hF, 1'b1, d_std);
         s_exp = 2'(i % N);
         expect_out("rr", 8'hA0 + 8'(i % N), s_exp);
      end

      // Fixed priority.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 4'hF, 1'b1, d_std);
         expect_out("fix", 8'hA0, 2'd0);
      end
      step(1'b1, 1'b1, 4'b1110, 1'b1, d_std);
      expect_out("fix_skip0", 8'hA1, 2'd1);

      // Backpressure.
      step(1'b0, 1'b0, 4'hF, 1'b1, d_std);
      step(1'b1, 1'b0, 4'hF, 1'b1, d_std);
      expect_out("bp_first", 8'hA0, 2'd0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 4'hF, 1'b0, d_std);
         expect_out("bp_hold", 8'hA0, 2'd0);
      end
      step(1'b1, 1'b0, 4'hF, 1'b1, d_std);
      expect_out("bp_resume", 8'hA1, 2'd1);

      // Sparse request then rotation continues after channel 2.
      d_sp = d_std;
      d_sp[2*T +: T] = 8'h55;
      step(1'b1, 1'b0, 4'b0100, 1'b1, d_sp);
      expect_out("sparse", 8'h55, 2'd2);
      step(1'b1, 1'b0, 4'hF, 1'b1, d_std);
      expect_out("sparse_next", 8'hA3, 2'd3);
      step(1'b1, 1'b0, 4'hF, 1'b1, d_std);
      expect_out("sparse_wrap", 8'hA0, 2'd0);

      // Reset mid-stream drops the held word and restarts at channel 0.
      step(1'b1, 1'b0, 4'b0100, 1'b1, d_std);
      expect_out("mid_pre", 8'hA2, 2'd2);
      step(1'b0, 1'b0, 4'hF, 1'b0, d_std);
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_data", out_data, 8'h00);
      step(1'b1, 1'b0, 4'hF, 1'b1, d_std);
      expect_out("mid_restart", 8'hA0, 2'd0);

      // Randomized traffic against the scoreboard.
      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < N; c++) d_rnd[c*T +: T] = 8'($urandom);
         step(($urandom_range(0, 49) != 0), 1'($urandom), 4'($urandom),
              ($urandom_range(0, 9) < 7), d_rnd);
      end

      step(1'b1, 1'b0, 4'h0, 1'b1, d_std);
      step(1'b1, 1'b0, 4'h0, 1'b1, d_std);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Registered, round-robin arbitrated N:1 stream multiplexer with N = 2**S channels, each T bits wide.
- Successor to the combinational recurse_mux. It adds per-channel valid/ready handshakes, automatic channel selection (round-robin or fixed-priority), and a one-entry output register.
- Sits at fan-in points where several producers share one downstream consumer.

Parameters:
- S, 2, select width; channel count N = 2**S (S >= 1).
- T, 8, data width per channel in bits (T >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- mode  input  1  arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- in_valid  input  2**S  bit i: channel i offers a word.
- in_ready  output  2**S  bit i: channel i's word is accepted this cycle.
- in_data  input  (2**S)*T  channel i occupies bits [i*T+T-1 : i*T].
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  T  registered selected word.
- out_sel  output  S  index of the channel that produced out_data.

Behaviour:
- Reset is synchronous: on a clk edge with rst_n = 0:
  - out_valid <= 0, out_data <= 0, out_sel <= 0.
  - Internal last_grant <= N-1, so the first round-robin search starts at channel 0.
- load = !out_valid || out_ready. This is combinational, so the register refills in the same cycle it drains and full throughput is 1 word/cycle.
- Grant is combinational from in_valid, mode and last_grant:
  - mode 0: first asserted in_valid scanning last_grant+1, last_grant+2, ..., wrapping modulo N, ending at last_grant itself.
  - mode 1: lowest asserted index.
- in_ready[g] = load && in_valid[g] for the granted g only. All other in_ready bits are 0, and all are 0 when no in_valid is set.
- On a clk edge with rst_n = 1, load = 1 and some in_valid set:
  - out_data <= channel g data, out_sel <= g, out_valid <= 1, last_grant <= g.
  - last_grant is updated in both modes.
- On a clk edge with load = 1 and no in_valid set: out_valid <= 0. out_data, out_sel and last_grant hold.
- On a clk edge with load = 0 (stalled): all registers hold and all in_ready are 0.
- Latency: an accepted word appears on out_data on the clk edge that accepts it (1 cycle).
- A mode change takes effect at the next arbitration; no state is flushed.
- Reset mid-operation: a word held in the output register is dropped (out_valid = 0 on the next cycle). No in_ready is asserted while rst_n = 0.
- Wrap-around: pointer arithmetic is modulo N on S bits, and natural overflow is the required behaviour.
- A channel that deasserts in_valid before being granted is simply skipped. There is no memory of past requests.
- in_data of non-granted channels is ignored.

Decomposition:
- Shared routing package holds:
  - the channel-count function N = 2**S,
  - the slice-index helper for the flattened in_data bus,
  - the mode encodings (RR = 0, FIXED = 1).
- One sub-module: rr_pick (combinational). Inputs are request vector, last_grant and mode. Outputs are grant index (S bits) and any_req.
- Data selection reuses recurse_mux #(.S(S), .T(T)), with ctrl = the grant index, feeding the output register.

Test Plan (S = 2, T = 8, channel i data = 8'hA0+i unless stated):
- Reset: rst_n = 0 for 2 clks with in_valid = 4'b1111 and out_ready = 1 -> out_valid = 0, out_data = 8'h00, out_sel = 0, in_ready = 4'b0000 throughout.
- Round-robin: mode = 0, in_valid = 4'b1111, out_ready = 1 -> out_sel = 0, 1, 2, 3, 0 on successive clks; out_data = A0, A1, A2, A3, A0; in_ready one-hot 0001, 0010, 0100, 1000, 0001.
- Fixed priority: mode = 1, in_valid = 4'b1111 -> out_sel = 0 every clk, in_ready = 4'b0001. Then in_valid = 4'b1110 -> out_sel = 1.
- Backpressure: mode 0, after the first word (A0) drop out_ready for 3 clks -> out_valid = 1, out_data = A0 stable, in_ready = 0000. Raise out_ready -> the next clk gives out_data = A1, out_sel = 1.
- Sparse: only in_valid[2] = 1 with data 8'h55 -> next clk out_data = 8'h55, out_sel = 2. Then in_valid = 4'b1111 -> the next grant is channel 3, then 0.
- Reset mid-stream: while out_valid = 1 and out_sel = 2, assert rst_n = 0 for one clk -> out_valid = 0, out_data = 0. Release with in_valid = 4'b1111 and mode = 0 -> the first grant is channel 0.
